// File: rtl/output_pref_pkg.sv
// output_pref_pkg: definitions shared by the SA output prefetcher slice.
//   state_t     - frame FSM states (IDLE, COLLECT, DRAIN, DONE)
//   *_DEF       - default lane widths / frame geometry, common with the
//                 input prefetcher so both sides agree on the buffer format.
package output_pref_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  localparam int N_DEF      = 8;   // output lane width (signed fixed point)
  localparam int IN_W_DEF   = 16;  // SA result lane width (signed)
  localparam int FRAC_DEF   = 4;   // right shift applied when cutting
  localparam int COLS_DEF   = 8;   // lanes per row
  localparam int ROWS_DEF   = 4;   // rows per frame
  localparam int ADDR_W_DEF = 4;   // output buffer address width

endpackage

// File: rtl/output_pref_if.sv
// output_pref_if: SA row stream and output-buffer write port.
//   sa_valid/sa_ready/sa_data          - SA result rows, lane c = [c*IN_W +: IN_W]
//   buf_ready                          - output buffer accepts a write this cycle
//   buf0_we/buf1_we/buf_addr/buf_wdata - bank write strobes, row address, cut row
// slave  = output_pref view, master = SA array / buffer side view.
interface output_pref_if
  import output_pref_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic                 sa_valid;
  logic                 sa_ready;
  logic [COLS*IN_W-1:0] sa_data;
  logic                 buf_ready;
  logic                 buf0_we;
  logic                 buf1_we;
  logic [ADDR_W-1:0]    buf_addr;
  logic [COLS*N-1:0]    buf_wdata;

  modport slave (
    input  sa_valid, sa_data, buf_ready,
    output sa_ready, buf0_we, buf1_we, buf_addr, buf_wdata
  );

  modport master (
    output sa_valid, sa_data, buf_ready,
    input  sa_ready, buf0_we, buf1_we, buf_addr, buf_wdata
  );

endinterface

// File: rtl/output_pref_cutting_sat.sv
// cutting_sat: one lane of the result cutter.
//   x   in  IN_W  signed SA result
//   y   out N     signed fixed-point lane: round half up, arithmetic shift by
//                 FRAC, clamp to the N-bit signed range
//   sat out 1     clamp was applied
module cutting_sat #(
  parameter int IN_W = 16,
  parameter int N    = 8,
  parameter int FRAC = 4
) (
  input  logic [IN_W-1:0] x,
  output logic [N-1:0]    y,
  output logic            sat
);

  localparam int RND = (FRAC > 0) ? (1 << (FRAC - 1)) : 0;
  localparam logic signed [IN_W:0] RND_C   = (IN_W+1)'(RND);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (N - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(1 << (N - 1)));

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] shifted;

  // One extra bit so adding the rounding constant to the most positive
  // input cannot wrap before the shift.
  always_comb begin
    ext     = $signed({x[IN_W-1], x}) + RND_C;
    shifted = ext >>> FRAC;
    y       = shifted[N-1:0];
    sat     = 1'b0;
    if (shifted > SAT_MAX) begin
      y   = SAT_MAX[N-1:0];
      sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      y   = SAT_MIN[N-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/output_pref.sv
// output_pref: write side of the SA prefetcher pair. Collects ROWS rows of
// SA results, cuts every lane to N-bit fixed point and writes the rows into
// the ping-pong output bank latched from buf_select at frame start.
//   clk, reset_n - clock (rising edge), asynchronous active-low reset
//   en           - start a frame (sampled in IDLE only)
//   buf_select   - target bank, latched at start
//   busy         - frame in progress (state != IDLE)
//   done         - one-cycle pulse at frame end
//   sat_flag     - sticky: some accepted lane clamped during this frame
//   bus          - SA row stream in, output buffer write port out
module output_pref
  import output_pref_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               buf_select,
  output logic               busy,
  output logic               done,
  output logic               sat_flag,
  output_pref_if.slave       bus
);

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] ROWS_C  = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] ROWS_M1 = CNT_W'(ROWS - 1);

  state_t state, state_nxt;

  logic [COLS*N-1:0] cut_row;
  logic [COLS-1:0]   lane_sat;

  logic [COLS*N-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_count, fifo_count_nxt;

  logic [CNT_W-1:0]  rd_cnt, wr_cnt, wr_cnt_nxt;
  logic              bank;

  logic              start, push, pop, sa_ready_i;

  for (genvar c = 0; c < COLS; c++) begin : g_cut
    cutting_sat #(
      .IN_W (IN_W),
      .N    (N),
      .FRAC (FRAC)
    ) u_cut (
      .x   (bus.sa_data[c*IN_W +: IN_W]),
      .y   (cut_row[c*N +: N]),
      .sat (lane_sat[c])
    );
  end

  assign sa_ready_i   = (state == COLLECT) && (fifo_count != 2'd2);
  assign bus.sa_ready = sa_ready_i;

  assign start = (state == IDLE) && en;
  assign push  = bus.sa_valid && sa_ready_i;
  assign pop   = (fifo_count != 2'd0) && bus.buf_ready;

  assign fifo_count_nxt = fifo_count + 2'(push) - 2'(pop);
  assign wr_cnt_nxt     = wr_cnt + CNT_W'(pop);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign bus.buf0_we   = pop && !bank;
  assign bus.buf1_we   = pop && bank;
  assign bus.buf_addr  = pop ? ADDR_W'(wr_cnt) : '0;
  assign bus.buf_wdata = pop ? fifo_mem[rd_ptr] : '0;

  // Transitions look at the post-edge counts so COLLECT closes on the
  // accepting cycle of the last row (no extra row can slip in) and DONE
  // follows the final write by exactly one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = COLLECT;
      COLLECT: if (push && (rd_cnt == ROWS_M1)) state_nxt = DRAIN;
      DRAIN:   if ((fifo_count_nxt == 2'd0) && (wr_cnt_nxt == ROWS_C)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fifo_count <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      bank       <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_count <= fifo_count_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (start) begin
        bank     <= buf_select;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (push) rd_cnt <= rd_cnt + 1'b1;
        wr_cnt <= wr_cnt_nxt;
        if (push && (|lane_sat)) sat_flag <= 1'b1;
      end
    end
  end

  // Storage only; validity is tracked by fifo_count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cut_row;
  end

endmodule
